// File: rtl/controladora_zonas_if.sv
`default_nettype none
// ============================================================================
// Module      : controladora_zonas_if
// Description : Sensor/button inputs and lamp/LED outputs of the zone controller
// Revision    : 1.0 - initial release
// ============================================================================
interface controladora_zonas_if #(
    parameter int N_ZONAS = 4
);
    logic [N_ZONAS-1:0] infravermelho;
    logic [N_ZONAS-1:0] push_button;
    logic [N_ZONAS-1:0] led;
    logic [N_ZONAS-1:0] saida;
    logic               ocupado;

    modport master (
        output infravermelho,
        output push_button,
        input  led,
        input  saida,
        input  ocupado
    );

    modport slave (
        input  infravermelho,
        input  push_button,
        output led,
        output saida,
        output ocupado
    );
endinterface
`default_nettype wire

// File: rtl/controladora_zonas.sv
`default_nettype none
// ============================================================================
// Module      : controladora_zonas
// Description : N-zone presence lighting controller with neighbour wake-up
//               and blinking pre-shutdown warning
// Revision    : 1.0 - initial release
// ============================================================================
module controladora_zonas #(
    parameter int N_ZONAS           = 4,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000,
    parameter int AVISO_T           = 3000,
    parameter int PISCA_T           = 250,
    parameter int VIZINHOS_EN       = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    controladora_zonas_if.slave bus_zonas
);
    localparam int c_TW = $clog2(AUTO_SHUTDOWN_T + 1);
    localparam int c_DW = $clog2(DEBOUNCE_P + 1);
    localparam int c_HW = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int c_FW = $clog2(2 * PISCA_T + 1);

    localparam logic [c_TW-1:0] c_T_SHUT   = c_TW'(AUTO_SHUTDOWN_T);
    localparam logic [c_TW-1:0] c_T_AVISO  = c_TW'(AVISO_T);
    localparam logic [c_TW-1:0] c_T_UM     = c_TW'(1);
    localparam logic [c_DW-1:0] c_DEB_MAX  = c_DW'(DEBOUNCE_P - 1);
    localparam logic [c_DW-1:0] c_DEB_UM   = c_DW'(1);
    localparam logic [c_HW-1:0] c_HOLD     = c_HW'(SWITCH_MODE_MIN_T);
    localparam logic [c_HW-1:0] c_HOLD_M1  = c_HW'(SWITCH_MODE_MIN_T - 1);
    localparam logic [c_HW-1:0] c_HOLD_UM  = c_HW'(1);
    localparam logic [c_FW-1:0] c_PISCA    = c_FW'(PISCA_T);
    localparam logic [c_FW-1:0] c_FASE_MAX = c_FW'(2 * PISCA_T - 1);
    localparam logic [c_FW-1:0] c_FASE_UM  = c_FW'(1);
    localparam logic            c_VIZ      = (VIZINHOS_EN != 0);

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'd0,
        AUTO_ON    = 2'd1,
        MANUAL_OFF = 2'd2,
        MANUAL_ON  = 2'd3
    } estado_t;

    logic [N_ZONAS-1:0] r_ir_m;
    logic [N_ZONAS-1:0] r_ir_s;
    logic [N_ZONAS-1:0] r_bt_m;
    logic [N_ZONAS-1:0] r_bt_s;
    logic [N_ZONAS+1:0] w_ir_pad;
    logic [N_ZONAS-1:0] w_saida_vec;
    logic [N_ZONAS-1:0] w_led_vec;
    logic               r_ocupado;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_m <= '0;
            r_ir_s <= '0;
            r_bt_m <= '0;
            r_bt_s <= '0;
        end else begin
            r_ir_m <= bus_zonas.infravermelho;
            r_ir_s <= r_ir_m;
            r_bt_m <= bus_zonas.push_button;
            r_bt_s <= r_bt_m;
        end
    end

    // Zero padding at both ends gives edge zones a single neighbour.
    assign w_ir_pad = {1'b0, r_ir_s, 1'b0};

    for (genvar gi = 0; gi < N_ZONAS; gi++) begin : g_zona
        logic [c_DW-1:0] r_deb_cnt;
        logic            r_deb;
        logic [c_HW-1:0] r_hold;
        logic            r_mode;
        logic            w_short;
        logic            w_ir_eff;
        estado_t         r_estado;
        estado_t         w_estado;
        logic [c_TW-1:0] r_timer;
        logic [c_TW-1:0] w_timer;
        logic [c_FW-1:0] r_fase;
        logic [c_FW-1:0] w_fase;
        logic            w_aviso_atual;
        logic            w_aviso_prox;
        logic            w_saida;
        logic            r_saida;
        logic            r_led;

        assign w_ir_eff = w_ir_pad[gi+1] | (c_VIZ & (w_ir_pad[gi] | w_ir_pad[gi+2]));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_deb_cnt <= '0;
                r_deb     <= 1'b0;
                r_hold    <= '0;
                r_mode    <= 1'b0;
            end else begin
                if (r_bt_s[gi] != r_deb) begin
                    if (r_deb_cnt == c_DEB_MAX) begin
                        r_deb     <= r_bt_s[gi];
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_DEB_UM;
                    end
                end else begin
                    r_deb_cnt <= '0;
                end
                // MODE pulses in the cycle the hold count becomes SWITCH_MODE_MIN_T.
                r_mode <= r_deb && (r_hold == c_HOLD_M1);
                if (!r_deb) begin
                    r_hold <= '0;
                end else if (r_hold != c_HOLD) begin
                    r_hold <= r_hold + c_HOLD_UM;
                end
            end
        end

        // r_hold still holds the press length during the first released cycle.
        assign w_short = !r_deb && (r_hold != '0) && (r_hold != c_HOLD);

        always_comb begin
            w_estado = r_estado;
            w_timer  = r_timer;
            case (r_estado)
                AUTO_OFF: begin
                    if (r_mode) begin
                        w_estado = MANUAL_OFF;
                    end else if (w_ir_eff) begin
                        w_estado = AUTO_ON;
                        w_timer  = c_T_SHUT;
                    end
                end
                AUTO_ON: begin
                    if (r_mode) begin
                        w_estado = MANUAL_ON;
                        w_timer  = '0;
                    end else if (w_ir_eff) begin
                        w_timer = c_T_SHUT;
                    end else if (r_timer <= c_T_UM) begin
                        w_estado = AUTO_OFF;
                        w_timer  = '0;
                    end else begin
                        w_timer = r_timer - c_T_UM;
                    end
                end
                MANUAL_OFF: begin
                    if (r_mode) begin
                        w_estado = AUTO_OFF;
                    end else if (w_short) begin
                        w_estado = MANUAL_ON;
                    end
                end
                MANUAL_ON: begin
                    if (r_mode) begin
                        w_estado = AUTO_OFF;
                    end else if (w_short) begin
                        w_estado = MANUAL_OFF;
                    end
                end
                default: begin
                    w_estado = AUTO_OFF;
                    w_timer  = '0;
                end
            endcase
        end

        // Timer is never 0 in AUTO_ON, so AVISO_T = 0 never enters the window.
        assign w_aviso_atual = (r_estado == AUTO_ON) && (r_timer <= c_T_AVISO);
        assign w_aviso_prox  = (w_estado == AUTO_ON) && (w_timer <= c_T_AVISO);

        always_comb begin
            w_fase = '0;
            if (w_aviso_prox && w_aviso_atual) begin
                w_fase = (r_fase == c_FASE_MAX) ? '0 : (r_fase + c_FASE_UM);
            end
        end

        assign w_saida = (w_estado == MANUAL_ON) ||
                         ((w_estado == AUTO_ON) && (!w_aviso_prox || (w_fase >= c_PISCA)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_estado <= AUTO_OFF;
                r_timer  <= '0;
                r_fase   <= '0;
                r_saida  <= 1'b0;
                r_led    <= 1'b0;
            end else begin
                r_estado <= w_estado;
                r_timer  <= w_timer;
                r_fase   <= w_fase;
                r_saida  <= w_saida;
                r_led    <= (w_estado == MANUAL_OFF) || (w_estado == MANUAL_ON);
            end
        end

        assign w_saida_vec[gi] = r_saida;
        assign w_led_vec[gi]   = r_led;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ocupado <= 1'b0;
        end else begin
            r_ocupado <= |w_saida_vec;
        end
    end

    assign bus_zonas.saida   = w_saida_vec;
    assign bus_zonas.led     = w_led_vec;
    assign bus_zonas.ocupado = r_ocupado;
endmodule
`default_nettype wire

// File: tb/tb_controladora_zonas.sv
`default_nettype none
// ============================================================================
// Module      : tb_controladora_zonas
// Description : Self-checking bench for controladora_zonas against a zone model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controladora_zonas;
    localparam int N  = 3;
    localparam int DP = 4;
    localparam int SM = 20;
    localparam int TS = 50;
    localparam int AV = 10;
    localparam int PT = 2;
    localparam int VZ = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controladora_zonas_if #(.N_ZONAS(N)) bus_zonas ();

    controladora_zonas #(
        .N_ZONAS(N), .DEBOUNCE_P(DP), .SWITCH_MODE_MIN_T(SM),
        .AUTO_SHUTDOWN_T(TS), .AVISO_T(AV), .PISCA_T(PT), .VIZINHOS_EN(VZ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_zonas(bus_zonas)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: delay lines for synchronisers, per-zone debounce run, press length,
    // mode flag, manual lamp flag, and remaining auto on-time.
    bit [N-1:0] m_ir1, m_ir2, m_b1, m_b2, m_deb;
    int         m_dcnt [N];
    int         m_run  [N];
    bit         m_man  [N];
    bit         m_lamp [N];
    int         m_tmr  [N];
    bit [N-1:0] e_led, e_saida;
    bit         e_ocup;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit lamp_out(input int z);
        if (m_man[z])       return m_lamp[z];
        if (m_tmr[z] > AV)  return 1'b1;
        if (m_tmr[z] > 0)   return (((AV - m_tmr[z]) / PT) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ir1 = '0; m_ir2 = '0; m_b1 = '0; m_b2 = '0; m_deb = '0;
        for (int z = 0; z < N; z++) begin
            m_dcnt[z] = 0; m_run[z] = 0; m_man[z] = 0; m_lamp[z] = 0; m_tmr[z] = 0;
        end
        e_led = '0; e_saida = '0; e_ocup = 1'b0;
    endtask

    task automatic model_step();
        bit [N-1:0] irx;
        bit mode, shrt;
        for (int z = 0; z < N; z++) begin
            irx[z] = m_ir2[z];
            if (VZ != 0) begin
                if (z > 0     && m_ir2[z-1]) irx[z] = 1'b1;
                if (z < N - 1 && m_ir2[z+1]) irx[z] = 1'b1;
            end
        end
        e_ocup = |e_saida;
        for (int z = 0; z < N; z++) begin
            mode = (m_run[z] == SM);
            shrt = !m_deb[z] && (m_run[z] >= 1) && (m_run[z] < SM);
            if (mode) begin
                if (m_man[z]) begin
                    m_man[z] = 1'b0;
                end else begin
                    m_man[z]  = 1'b1;
                    m_lamp[z] = (m_tmr[z] > 0);
                end
                m_tmr[z] = 0;
            end else if (m_man[z]) begin
                if (shrt) m_lamp[z] = !m_lamp[z];
            end else if (irx[z]) begin
                m_tmr[z] = TS;
            end else if (m_tmr[z] > 0) begin
                m_tmr[z]--;
            end
            if (m_deb[z]) m_run[z] = (m_run[z] > SM) ? SM + 1 : m_run[z] + 1;
            else          m_run[z] = 0;
            if (m_b2[z] != m_deb[z]) begin
                m_dcnt[z]++;
                if (m_dcnt[z] == DP) begin
                    m_deb[z]  = m_b2[z];
                    m_dcnt[z] = 0;
                end
            end else begin
                m_dcnt[z] = 0;
            end
        end
        m_ir2 = m_ir1; m_ir1 = bus_zonas.infravermelho;
        m_b2  = m_b1;  m_b1  = bus_zonas.push_button;
        for (int z = 0; z < N; z++) begin
            e_saida[z] = lamp_out(z);
            e_led[z]   = m_man[z];
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        cyc++;
        if (rst) model_reset();
        else     model_step();
        #1;
        check("led", bus_zonas.led, e_led);
        check("saida", bus_zonas.saida, e_saida);
        check("ocupado", bus_zonas.ocupado, e_ocup);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int brem [N];

    initial begin
        bus_zonas.infravermelho = '0;
        bus_zonas.push_button   = '0;
        edges(3);
        check("rst_saida", bus_zonas.saida, 0);
        check("rst_led", bus_zonas.led, 0);
        check("rst_ocupado", bus_zonas.ocupado, 0);
        @(negedge clk); rst = 1'b0;
        idle(3);

        // Single-cycle pulse on zone 1 wakes all three zones.
        bus_zonas.infravermelho = 3'b010;
        @(posedge clk);
        @(negedge clk); bus_zonas.infravermelho = '0;
        edges(2);  check("wake_all", bus_zonas.saida, 3'b111);
        edges(1);  check("ocupado_lag", bus_zonas.ocupado, 1);
        edges(38); check("solid_last", bus_zonas.saida, 3'b111);
        edges(1);  check("blink_first_off", bus_zonas.saida, 3'b000);
        edges(2);  check("blink_first_on", bus_zonas.saida, 3'b111);
        edges(8);  check("auto_off", bus_zonas.saida, 3'b000);
        edges(1);  check("ocupado_off", bus_zonas.ocupado, 0);
        idle(5);

        // Re-pulse zone 0 inside the warning window.
        bus_zonas.infravermelho = 3'b010;
        @(posedge clk);
        @(negedge clk); bus_zonas.infravermelho = '0;
        repeat (42) @(posedge clk);
        @(negedge clk); bus_zonas.infravermelho = 3'b001;
        @(posedge clk);
        @(negedge clk); bus_zonas.infravermelho = '0;
        edges(2); check("reload_solid", bus_zonas.saida, 3'b111);
        edges(7); check("zone2_off_only", bus_zonas.saida, 3'b011);
        idle(60);

        // Bouncy long press on button 2 while zone 2 is occupied.
        bus_zonas.infravermelho = 3'b100;
        idle(5);
        for (int k = 0; k < 4; k++) begin
            bus_zonas.push_button[2] = 1'b1; idle(2);
            bus_zonas.push_button[2] = 1'b0; idle(2);
        end
        bus_zonas.push_button[2] = 1'b1; idle(30);
        bus_zonas.push_button[2] = 1'b0;
        bus_zonas.infravermelho  = '0;
        idle(10);
        check("mode_led", bus_zonas.led, 3'b100);
        check("mode_saida2", bus_zonas.saida[2], 1);

        // Short press toggles the manual lamp; sensor ignored; long hold back to auto.
        bus_zonas.push_button[2] = 1'b1; idle(8);
        bus_zonas.push_button[2] = 1'b0; idle(12);
        check("short_toggle", bus_zonas.saida[2], 0);
        check("short_led", bus_zonas.led[2], 1);
        bus_zonas.infravermelho = 3'b100; idle(3);
        bus_zonas.infravermelho = '0;     idle(8);
        check("manual_ignores_ir", bus_zonas.saida[2], 0);
        bus_zonas.push_button[2] = 1'b1; idle(25);
        bus_zonas.push_button[2] = 1'b0; idle(8);
        check("back_auto_led", bus_zonas.led[2], 0);
        check("back_auto_saida", bus_zonas.saida[2], 0);
        idle(60);

        // Random sensors and bouncy/long button activity.
        for (int z = 0; z < N; z++) brem[z] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int z = 0; z < N; z++) begin
                if (brem[z] == 0) begin
                    bus_zonas.push_button[z] = ($urandom_range(0, 2) == 0);
                    brem[z] = $urandom_range(1, 40);
                end else begin
                    brem[z]--;
                end
                bus_zonas.infravermelho[z] = ($urandom_range(0, 39) == 0);
            end
        end

        // Async reset with zones lit and button 0 held.
        bus_zonas.push_button   = 3'b001;
        bus_zonas.infravermelho = 3'b111;
        idle(10);
        rst = 1'b1;
        #1;
        check("async_rst_saida", bus_zonas.saida, 0);
        check("async_rst_led", bus_zonas.led, 0);
        check("async_rst_ocupado", bus_zonas.ocupado, 0);
        bus_zonas.infravermelho = '0;
        idle(3);
        rst = 1'b0;
        idle(40);
        bus_zonas.push_button = '0;
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
